// File: rtl/rx_frame_buf.sv
// SPI-style frame receiver: assembles NUM_FIELDS lanes per frame into a DEPTH-entry FIFO.
// Optional feature macro: RX_PARITY_EN (adds a trailing XOR parity lane per frame).
module rx_frame_buf #(
   parameter int LANE_W     = 4,
   parameter int NUM_FIELDS = 5,
   parameter int DEPTH      = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         spi_clk,
   input  logic                         spi_w,
   input  logic [LANE_W-1:0]            mosi,
   input  logic                         frame_ready,
   input  logic                         ovf_clr,
   output logic                         frame_valid,
   output logic [NUM_FIELDS*LANE_W-1:0] frame_data,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
   output logic                         overflow,
   output logic                         parity_err
);

`ifdef RX_PARITY_EN
   localparam int F = NUM_FIELDS + 1;
`else
   localparam int F = NUM_FIELDS;
`endif
   localparam int CNT_W = $clog2(F);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int FW    = NUM_FIELDS * LANE_W;
   localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
   localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(F - 1);

   logic              spi_clk_prev;
   logic              rise, sample, complete, frame_ok;
   logic              push_req, push, pop, ovf_set;
   logic [CNT_W-1:0]  fcnt;
   logic [LANE_W-1:0] fields [NUM_FIELDS];
   logic [FW-1:0]     frame_new;
   logic [FW-1:0]     mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign rise     = spi_clk & ~spi_clk_prev;
   assign sample   = rise & spi_w;
   assign complete = sample && (fcnt == LAST_C);

   // Field 0 lands in the MSBs; without parity the final field bypasses the assembly register.
   always_comb begin
      frame_new = '0;
      for (int unsigned i = 0; i < NUM_FIELDS; i++)
         frame_new[(NUM_FIELDS-1-i)*LANE_W +: LANE_W] = fields[i];
`ifndef RX_PARITY_EN
      frame_new[LANE_W-1:0] = mosi;
`endif
   end

`ifdef RX_PARITY_EN
   logic [LANE_W-1:0] par;
   always_comb begin
      par = '0;
      for (int unsigned i = 0; i < NUM_FIELDS; i++)
         par = par ^ fields[i];
      frame_ok = (par == mosi);
   end
`else
   assign frame_ok = 1'b1;
`endif

   assign push_req    = complete & frame_ok;
   assign frame_valid = (fifo_count != '0);
   assign pop         = frame_valid & frame_ready;
   assign push        = push_req & ((fifo_count != DEPTH_C) | pop);
   assign ovf_set     = push_req & ~push;
   assign frame_data  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         spi_clk_prev <= 1'b0;
         fcnt         <= '0;
         for (int unsigned i = 0; i < NUM_FIELDS; i++)
            fields[i] <= '0;
      end else begin
         spi_clk_prev <= spi_clk;
         if (!spi_w)
            fcnt <= '0;
         else if (rise)
            fcnt <= (fcnt == LAST_C) ? '0 : fcnt + 1'b1;
         for (int unsigned i = 0; i < NUM_FIELDS; i++)
            if (sample && fcnt == CNT_W'(i))
               fields[i] <= mosi;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            mem[i] <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= frame_new;
            wr_ptr      <= ptr_next(wr_ptr);
         end
         if (pop)
            rd_ptr <= ptr_next(rd_ptr);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
         if (ovf_set)
            overflow <= 1'b1;
         else if (ovf_clr)
            overflow <= 1'b0;
      end
   end

`ifdef RX_PARITY_EN
   always_ff @(posedge clk) begin
      if (!rst_n)
         parity_err <= 1'b0;
      else if (complete && !frame_ok)
         parity_err <= 1'b1;
      else if (ovf_clr)
         parity_err <= 1'b0;
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_frame_buf.sv
// Directed self-checking bench for rx_frame_buf at default parameters.
// Honours RX_PARITY_EN by appending the XOR parity lane to every frame.
module tb_rx_frame_buf;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        spi_clk = 1'b0;
   logic        spi_w = 1'b0;
   logic [3:0]  mosi = '0;
   logic        frame_ready = 1'b0;
   logic        ovf_clr = 1'b0;
   logic        frame_valid;
   logic [19:0] frame_data;
   logic [1:0]  fifo_count;
   logic        overflow;
   logic        parity_err;

   int checks = 0;
   int failures = 0;

   rx_frame_buf #(.LANE_W(4), .NUM_FIELDS(5), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_w(spi_w), .mosi(mosi),
      .frame_ready(frame_ready), .ovf_clr(ovf_clr), .frame_valid(frame_valid),
      .frame_data(frame_data), .fifo_count(fifo_count), .overflow(overflow),
      .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One SPI transfer: one clk cycle high, one low.
   task automatic lane(input logic [3:0] v);
      mosi = v; spi_w = 1'b1; spi_clk = 1'b1;
      @(negedge clk);
      spi_clk = 1'b0;
      @(negedge clk);
   endtask

   // Sends a frame; returns just after the edge that samples the final lane,
   // with frame_ready driven to rdy_last during that final lane.
   task automatic send_open(input logic [19:0] f, input logic rdy_last);
      logic [3:0] p;
      p = f[19:16] ^ f[15:12] ^ f[11:8] ^ f[7:4] ^ f[3:0];
      lane(f[19:16]); lane(f[15:12]); lane(f[11:8]); lane(f[7:4]);
`ifdef RX_PARITY_EN
      lane(f[3:0]);
      mosi = p;
`else
      mosi = f[3:0];
`endif
      frame_ready = rdy_last; spi_w = 1'b1; spi_clk = 1'b1;
      @(negedge clk);
      spi_clk = 1'b0;
   endtask

   task automatic send(input logic [19:0] f);
      send_open(f, 1'b0);
      tick(1);
   endtask

   task automatic pop1;
      frame_ready = 1'b1;
      tick(1);
      frame_ready = 1'b0;
   endtask

   initial begin
      // Reset state
      tick(2);
      chk("rst_valid", frame_valid, 0);
      chk("rst_data", frame_data, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_perr", parity_err, 0);
      rst_n = 1'b1;
      tick(1);

      // Single frame and latency
      send_open(20'h12345, 1'b0);
      chk("single_valid", frame_valid, 1);
      chk("single_data", frame_data, 20'h12345);
      chk("single_count", fifo_count, 1);
      tick(1);
      pop1;
      chk("single_pop_valid", frame_valid, 0);
      chk("single_pop_count", fifo_count, 0);

      // Abort mid-frame
      lane(4'h7); lane(4'h7); lane(4'h7);
      spi_w = 1'b0;
      tick(2);
      send(20'hABCDE);
      chk("abort_count", fifo_count, 1);
      chk("abort_data", frame_data, 20'hABCDE);
      pop1;
      chk("abort_drain", fifo_count, 0);

      // Overflow and arrival order
      send(20'h11111);
      send(20'h22222);
      chk("ovf_full_count", fifo_count, 2);
      chk("ovf_not_yet", overflow, 0);
      send(20'h33333);
      chk("ovf_count", fifo_count, 2);
      chk("ovf_flag", overflow, 1);
      chk("ovf_head0", frame_data, 20'h11111);
      pop1;
      chk("ovf_head1", frame_data, 20'h22222);
      chk("ovf_count1", fifo_count, 1);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      chk("ovf_clr", overflow, 0);
      pop1;
      chk("ovf_drain", fifo_count, 0);

      // Full FIFO with a simultaneous pop
      send(20'h12121);
      send(20'h34343);
      send_open(20'h44444, 1'b1);
      frame_ready = 1'b0;
      chk("fullpop_ovf", overflow, 0);
      chk("fullpop_count", fifo_count, 2);
      chk("fullpop_head", frame_data, 20'h34343);
      pop1;
      chk("fullpop_third", frame_data, 20'h44444);
      chk("fullpop_count1", fifo_count, 1);
      pop1;
      chk("fullpop_empty", frame_valid, 0);

      // Reset mid-frame with populated FIFO and flags
      send(20'h13579);
      send(20'h24680);
      send(20'h11223);
      chk("pre_rst_ovf", overflow, 1);
      lane(4'h9); lane(4'h9);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      chk("mid_rst_valid", frame_valid, 0);
      chk("mid_rst_data", frame_data, 0);
      chk("mid_rst_count", fifo_count, 0);
      chk("mid_rst_ovf", overflow, 0);
      send(20'h54321);
      chk("post_rst_data", frame_data, 20'h54321);
      chk("post_rst_count", fifo_count, 1);
      pop1;

`ifdef RX_PARITY_EN
      // Good parity accepted, bad parity rejected
      send(20'h12345);
      chk("par_ok_count", fifo_count, 1);
      chk("par_ok_data", frame_data, 20'h12345);
      chk("par_ok_err", parity_err, 0);
      pop1;
      lane(4'h1); lane(4'h2); lane(4'h3); lane(4'h4); lane(4'h5); lane(4'h0);
      chk("par_bad_count", fifo_count, 0);
      chk("par_bad_err", parity_err, 1);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      chk("par_clr", parity_err, 0);
`else
      chk("perr_tied", parity_err, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
